// File: rtl/lpc_sniffer_pkg.sv
// lpc_sniffer_pkg: shared constants for the LPC sniffer record path.
// Holds the record-drain FSM state encoding, ASCII codes used by the hex
// output mode, the 8N1 frame length and a nibble-to-hex-character helper.
package lpc_sniffer_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_SEND  = 2'd3;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam int FRAME_BITS = 10;
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? ASCII_ZERO + {4'd0, n} : ASCII_A + {4'd0, n - 4'd10};
    endfunction
endpackage

// File: rtl/lpc_record_uart_tx.sv
// uart_tx: byte-wide 8N1 serialiser (start 0, 8 data bits LSB first, stop 1).
// Ports: clk; reset (async, active-low); tx_start (load tx_data and begin a
// frame); tx_data[7:0]; tx_busy (low when a new tx_start is accepted, which
// includes the final cycle of a stop bit so frames abut); uart_tx (line, idle 1).
module uart_tx
    import lpc_sniffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       uart_tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    logic          active;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud;
    logic [8:0]    sh;
    logic          bit_end;
    logic          last;
    assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
    assign last    = active && bit_end && bit_cnt == 4'(FRAME_BITS - 1);
    // Report idle during the last stop cycle so the parent can chain the next byte.
    assign tx_busy = active && !last;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            baud    <= '0;
            sh      <= '0;
            uart_tx <= 1'b1;
        end else if (tx_start && !tx_busy) begin
            active  <= 1'b1;
            bit_cnt <= '0;
            baud    <= '0;
            sh      <= {1'b1, tx_data};
            uart_tx <= 1'b0;
        end else if (active) begin
            baud <= bit_end ? '0 : baud + 1'b1;
            if (bit_end) begin
                active  <= !last;
                bit_cnt <= last ? '0 : bit_cnt + 1'b1;
                sh      <= sh >> 1;
                uart_tx <= last ? 1'b1 : sh[0];
            end
        end
endmodule

// File: rtl/lpc_record_uart.sv
// lpc_record_uart: pops records from the ring buffer and ships them over UART.
// Ports: clk; reset (async, active-low); empty (ring buffer has no record);
// read_data[DW-1:0] (valid the cycle after read_clk_enable);
// read_clk_enable (one-cycle pop strobe); uart_tx (serial line, idle 1);
// busy (high from the pop strobe until the record's last stop bit ends).
// Build option LPC_UART_HEX_ASCII_EN: send DW/4 uppercase hex characters plus
// CR LF instead of DW/8 raw bytes, most significant first in both modes.
module lpc_record_uart
    import lpc_sniffer_pkg::*;
#(
    parameter int DW           = 32,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          empty,
    input  logic [DW-1:0] read_data,
    output logic          read_clk_enable,
    output logic          uart_tx,
    output logic          busy
);
`ifdef LPC_UART_HEX_ASCII_EN
    localparam int STEP = 4;
    localparam int NCH  = DW / 4 + 2;
`else
    localparam int STEP = 8;
    localparam int NCH  = DW / 8;
`endif
    localparam int CW = $clog2(NCH + 1);
    logic [1:0]      state;
    logic [1:0]      next_state;
    logic [DW-1:0]   rec;
    logic [DW-1:0]   src;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   nidx;
    logic [STEP-1:0] top;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    // The first character comes straight off read_data during LOAD; later ones
    // come from the captured record, which is pre-shifted by one symbol.
    assign src  = (state == ST_LOAD) ? read_data : rec;
    assign nidx = (state == ST_LOAD) ? '0 : cnt + 1'b1;
    assign top  = src[DW-1 -: STEP];
`ifdef LPC_UART_HEX_ASCII_EN
    assign tx_data = (nidx < CW'(DW / 4)) ? hex_char(top) : (nidx == CW'(DW / 4)) ? ASCII_CR : ASCII_LF;
`else
    assign tx_data = top;
`endif
    assign tx_start = (state == ST_LOAD) || (state == ST_SEND && !tx_busy && cnt != CW'(NCH - 1));
    always_comb
        next_state = (state == ST_IDLE)  ? (empty ? ST_IDLE : ST_FETCH) :
                     (state == ST_FETCH) ? ST_LOAD :
                     (state == ST_LOAD)  ? ST_SEND :
                     (!tx_busy && cnt == CW'(NCH - 1)) ? ST_IDLE : ST_SEND;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state           <= ST_IDLE;
            read_clk_enable <= 1'b0;
            busy            <= 1'b0;
            rec             <= '0;
            cnt             <= '0;
        end else begin
            state           <= next_state;
            read_clk_enable <= next_state == ST_FETCH;
            busy            <= next_state != ST_IDLE;
            if (tx_start) begin
                rec <= src << STEP;
                cnt <= nidx;
            end
        end
    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .uart_tx  (uart_tx)
    );
endmodule

// File: tb/tb_lpc_record_uart.sv
// tb_lpc_record_uart: self-checking bench for lpc_record_uart with a queue-based
// ring buffer model, a mid-bit sampling UART receiver and an expected-character
// model derived from the record word.
module tb_lpc_record_uart;
    localparam int DW  = 32;
    localparam int CPB = 4;
`ifdef LPC_UART_HEX_ASCII_EN
    localparam int NCH = DW / 4 + 2;
`else
    localparam int NCH = DW / 8;
`endif
    localparam int REC = 2 + NCH * 10 * CPB;
    localparam int GAP = REC + 1;

    typedef struct {
        logic [31:0] word;
        string       hx;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          empty;
    logic [DW-1:0] read_data;
    logic          read_clk_enable;
    logic          uart_tx;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pops     = 0;
    int busy_cyc = 0;
    int quiet_bad = 0;
    int frame_err = 0;
    int fall_cyc = 0;
    logic quiet = 0;
    logic force_empty = 1;
    logic pop_now;
    logic [31:0] fifo[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          pop_cyc[$];
    logic        rx_on = 0;
    int          rx_t = 0;
    int          rx_k = 0;
    logic [7:0]  rx_byte = 0;
    vec_t        vecs[6];

    lpc_record_uart #(.DW(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .reset           (reset),
        .empty           (empty),
        .read_data       (read_data),
        .read_clk_enable (read_clk_enable),
        .uart_tx         (uart_tx),
        .busy            (busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Ring buffer model: a pop strobe seen at an edge presents the next word after it.
    always @(posedge clk) begin
        cyc++;
        pop_now = read_clk_enable;
        #1;
        if (pop_now) read_data = (fifo.size() > 0) ? fifo.pop_front() : 32'hxxxxxxxx;
        empty = force_empty || fifo.size() == 0;
    end

    always @(negedge clk) begin
        if (read_clk_enable) begin
            pops++;
            pop_cyc.push_back(cyc);
        end
        if (busy) busy_cyc++;
        if (quiet && (uart_tx !== 1'b1 || read_clk_enable !== 1'b0 || busy !== 1'b0)) quiet_bad++;
    end

    // 8N1 receiver sampling the middle of each bit.
    always @(negedge clk) begin
        if (!reset) rx_on = 0;
        else if (!rx_on) begin
            if (uart_tx === 1'b0) begin
                rx_on = 1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2) begin
                rx_k = rx_t / CPB;
                if (rx_k == 0) begin
                    if (uart_tx !== 1'b0) frame_err++;
                end else if (rx_k <= 8) rx_byte[rx_k-1] = uart_tx;
                else begin
                    if (uart_tx !== 1'b1) frame_err++;
                    rx_q.push_back(rx_byte);
                    rx_on = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_exp(input logic [31:0] w, input string hx);
`ifdef LPC_UART_HEX_ASCII_EN
        for (int i = 0; i < hx.len(); i++) exp_q.push_back(hx[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'(w >> (8 * i)));
`endif
    endtask

    task automatic push(input logic [31:0] w, input string hx);
        if (empty) fall_cyc = cyc;
        fifo.push_back(w);
        add_exp(w, hx);
        empty = force_empty;
    endtask

    task automatic clear();
        rx_q.delete();
        exp_q.delete();
        pop_cyc.delete();
        pops = 0;
        busy_cyc = 0;
        frame_err = 0;
        quiet_bad = 0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || !empty) && n < max_cyc);
        repeat (3) @(negedge clk);
        check({name, "_timeout"}, n < max_cyc, 1);
    endtask

    task automatic compare_rx(input string name);
        check({name, "_nchars"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_char%0d", name, i), rx_q[i], exp_q[i]);
        check({name, "_framing"}, frame_err, 0);
    endtask

    initial begin
        int n;
        int base_p;
        int base_rx;
        reset = 0;
        empty = 1;
        read_data = '0;
        vecs[0] = '{32'h0123ABCF, "0123ABCF"};
        vecs[1] = '{32'h00000000, "00000000"};
        vecs[2] = '{32'hFFFFFFFF, "FFFFFFFF"};
        for (int i = 3; i < 6; i++) begin
            vecs[i].word = $urandom;
            vecs[i].hx = $sformatf("%08X", vecs[i].word);
        end
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_rce", read_clk_enable, 0);
        check("rst_busy", busy, 0);
        reset = 1;
        quiet = 1;
        repeat (1000) @(negedge clk);
        quiet = 0;
        check("idle_quiet", quiet_bad, 0);

        force_empty = 0;
        clear();
        push(32'hDEADBEEF, "DEADBEEF");
        wait_done("single", 2000);
        check("single_pops", pops, 1);
        check("single_pop_latency", (pop_cyc.size() > 0) ? pop_cyc[0] - fall_cyc : -1, 1);
        check("single_busy_len", busy_cyc, REC);
        compare_rx("single");

        for (int v = 0; v < 6; v++) begin
            clear();
            push(vecs[v].word, vecs[v].hx);
            wait_done($sformatf("vec%0d", v), 2000);
            check($sformatf("vec%0d_pops", v), pops, 1);
            check($sformatf("vec%0d_busy_len", v), busy_cyc, REC);
            compare_rx($sformatf("vec%0d", v));
        end

        clear();
        push(32'h00000000, "00000000");
        push(32'hFFFFFFFF, "FFFFFFFF");
        wait_done("two", 4000);
        check("two_pops", pops, 2);
        check("two_gap", (pop_cyc.size() > 1) ? pop_cyc[1] - pop_cyc[0] : -1, GAP);
        check("two_busy_len", busy_cyc, 2 * REC);
        compare_rx("two");

        clear();
        push(32'h13579BDF, "13579BDF");
        push(32'h2468ACE0, "2468ACE0");
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (busy && n < 2000) begin
            force_empty = 1'($urandom_range(0, 1));
            empty = force_empty || fifo.size() == 0;
            @(negedge clk);
            n++;
        end
        check("toggle_pops_first", pops, 1);
        force_empty = 0;
        empty = fifo.size() == 0;
        wait_done("toggle", 2000);
        check("toggle_pops_total", pops, 2);
        compare_rx("toggle");

        clear();
        push(32'hC0FFEE11, "C0FFEE11");
        n = 0;
        while (!(rx_q.size() == 1 && uart_tx === 1'b0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", n < 1000, 1);
        check("mid_first_char", rx_q.size() > 0 ? rx_q[0] : 8'hxx, exp_q[0]);
        reset = 0;
        #1;
        check("mid_rst_uart_tx", uart_tx, 1);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        force_empty = 1;
        empty = 1;
        base_p = pops;
        base_rx = rx_q.size();
        reset = 1;
        quiet = 1;
        repeat (300) @(negedge clk);
        quiet = 0;
        check("after_rst_quiet", quiet_bad, 0);
        check("after_rst_pops", pops, base_p);
        check("after_rst_frames", rx_q.size(), base_rx);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
